// File: rtl/alu_rs_pkg.sv
// alu_rs_pkg: shared ROB tag width, ALU/branch opcodes and reservation-station types
package alu_rs_pkg;
  localparam int ROB_WIDTH = 4;
  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SLL  = 5'b00001;
  localparam logic [4:0] OP_SLT  = 5'b00010;
  localparam logic [4:0] OP_SLTU = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_SRL  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_AND  = 5'b00111;
  localparam logic [4:0] OP_SUB  = 5'b01000;
  localparam logic [4:0] OP_SRA  = 5'b01101;
  localparam logic [4:0] OP_BEQ  = 5'b10000;
  localparam logic [4:0] OP_BNE  = 5'b10001;
  localparam logic [4:0] OP_BLT  = 5'b10100;
  localparam logic [4:0] OP_BGE  = 5'b10101;
  localparam logic [4:0] OP_BLTU = 5'b10110;
  localparam logic [4:0] OP_BGEU = 5'b10111;
  typedef logic [ROB_WIDTH-1:0] tag_t;
  typedef struct packed {
    logic        ready;
    tag_t        rob;
    logic [31:0] value;
  } cdb_t;
  typedef struct packed {
    logic        pend;
    tag_t        tag;
    logic [31:0] val;
  } opnd_t;
  typedef struct packed {
    logic [4:0]  op;
    opnd_t       j;
    opnd_t       k;
    tag_t        rob;
    logic [31:0] tj;
    logic [31:0] fj;
  } entry_t;
  function automatic opnd_t wake(opnd_t o, cdb_t a, cdb_t l);
    logic ha, hl;
    ha = o.pend && a.ready && o.tag == a.rob;
    hl = o.pend && l.ready && o.tag == l.rob;
    return ha ? '{1'b0, o.tag, a.value} : hl ? '{1'b0, o.tag, l.value} : o;
  endfunction
endpackage

// File: rtl/rs_select.sv
// rs_select: lowest-index priority encoders for the free slot and the issuable slot
module rs_select #(
  parameter int N = 8
) (
  input  logic [N-1:0]         valid_i,
  input  logic [N-1:0]         ready_i,
  output logic [$clog2(N)-1:0] free_idx_o,
  output logic                 free_found_o,
  output logic [$clog2(N)-1:0] issue_idx_o,
  output logic                 issue_found_o
);
  always_comb begin
    free_idx_o    = '0;
    free_found_o  = 1'b0;
    issue_idx_o   = '0;
    issue_found_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!valid_i[i]) begin
        free_idx_o   = i[$clog2(N)-1:0];
        free_found_o = 1'b1;
      end
      if (ready_i[i]) begin
        issue_idx_o   = i[$clog2(N)-1:0];
        issue_found_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/alu_rs.sv
// alu_rs: ALU reservation station with CDB wakeup/bypass and single in-order-priority issue
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int RS_SIZE = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear,
  input  logic                 disp_valid,
  input  logic [4:0]           disp_op,
  input  logic [31:0]          disp_vj,
  input  logic [ROB_WIDTH-1:0] disp_qj,
  input  logic                 disp_qj_valid,
  input  logic [31:0]          disp_vk,
  input  logic [ROB_WIDTH-1:0] disp_qk,
  input  logic                 disp_qk_valid,
  input  logic [ROB_WIDTH-1:0] disp_rob,
  input  logic [31:0]          disp_true_jaddr,
  input  logic [31:0]          disp_false_jaddr,
  output logic                 full,
  input  logic                 cdb_alu_ready,
  input  logic [ROB_WIDTH-1:0] cdb_alu_rob,
  input  logic [31:0]          cdb_alu_value,
  input  logic                 cdb_lsb_ready,
  input  logic [ROB_WIDTH-1:0] cdb_lsb_rob,
  input  logic [31:0]          cdb_lsb_value,
  output logic                 calc_enable,
  output logic [31:0]          lhs,
  output logic [31:0]          rhs,
  output logic [4:0]           op,
  output logic [ROB_WIDTH-1:0] rob_dep,
  output logic [31:0]          true_jaddr,
  output logic [31:0]          false_jaddr
);
  localparam int IW = $clog2(RS_SIZE);
  logic [RS_SIZE-1:0] valid_q, valid_d, issuable;
  entry_t [RS_SIZE-1:0] ent_q, ent_d;
  logic [IW-1:0] free_idx, issue_idx;
  logic free_found, issue_found;
  cdb_t cdb_a, cdb_l;
  logic calc_d;
  logic [31:0] lhs_d, rhs_d, tj_d, fj_d;
  logic [4:0] op_d;
  tag_t rob_d;
  assign cdb_a = {cdb_alu_ready, cdb_alu_rob, cdb_alu_value};
  assign cdb_l = {cdb_lsb_ready, cdb_lsb_rob, cdb_lsb_value};
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) issuable[i] = valid_q[i] & ~ent_q[i].j.pend & ~ent_q[i].k.pend;
  end
  rs_select #(.N(RS_SIZE)) u_sel (
    .valid_i      (valid_q),
    .ready_i      (issuable),
    .free_idx_o   (free_idx),
    .free_found_o (free_found),
    .issue_idx_o  (issue_idx),
    .issue_found_o(issue_found)
  );
  assign full = ~free_found;
  // the free slot is never valid, so dispatch cannot collide with wakeup or issue
  always_comb begin
    valid_d = valid_q;
    ent_d   = ent_q;
    for (int i = 0; i < RS_SIZE; i++) begin
      ent_d[i].j = wake(ent_q[i].j, cdb_a, cdb_l);
      ent_d[i].k = wake(ent_q[i].k, cdb_a, cdb_l);
    end
    if (issue_found) valid_d[issue_idx] = 1'b0;
    if (disp_valid && free_found) begin
      valid_d[free_idx] = 1'b1;
      ent_d[free_idx] = '{op: disp_op,
                          j:  wake('{disp_qj_valid, disp_qj, disp_vj}, cdb_a, cdb_l),
                          k:  wake('{disp_qk_valid, disp_qk, disp_vk}, cdb_a, cdb_l),
                          rob: disp_rob, tj: disp_true_jaddr, fj: disp_false_jaddr};
    end
    if (clear) valid_d = '0;
    calc_d = issue_found && !clear;
    lhs_d  = calc_d ? ent_q[issue_idx].j.val : '0;
    rhs_d  = calc_d ? ent_q[issue_idx].k.val : '0;
    op_d   = calc_d ? ent_q[issue_idx].op : '0;
    rob_d  = calc_d ? ent_q[issue_idx].rob : '0;
    tj_d   = calc_d ? ent_q[issue_idx].tj : '0;
    fj_d   = calc_d ? ent_q[issue_idx].fj : '0;
  end
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid_q     <= '0;
      calc_enable <= 1'b0;
      lhs         <= '0;
      rhs         <= '0;
      op          <= '0;
      rob_dep     <= '0;
      true_jaddr  <= '0;
      false_jaddr <= '0;
    end else if (rdy_in) begin
      valid_q     <= valid_d;
      calc_enable <= calc_d;
      lhs         <= lhs_d;
      rhs         <= rhs_d;
      op          <= op_d;
      rob_dep     <= rob_d;
      true_jaddr  <= tj_d;
      false_jaddr <= fj_d;
    end
  end
  always_ff @(posedge clk_in) begin
    if (rdy_in) ent_q <= ent_d;
  end
endmodule
